// File: rtl/uart_ctrl_if.sv
// Bus bundle between the UART controller, its config register, the shift engines and the MCU bus.
interface uart_ctrl_if;
  logic [7:0] conf;
  logic       tx_busy;
  logic       tx_done;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_read;
  logic       baud_tick;
  logic       tx_start;
  logic       loadTXactive;
  logic       loadTXdone;
  logic       loadRXdone;
  logic [7:0] rx_buf;
  logic       rx_valid;
  logic       rx_overrun;
  logic       tx_timeout;
  logic       irq;

  modport slave (
    input  conf, tx_busy, tx_done, rx_done, rx_data, rx_read,
    output baud_tick, tx_start, loadTXactive, loadTXdone, loadRXdone,
           rx_buf, rx_valid, rx_overrun, tx_timeout, irq
  );

  modport master (
    output conf, tx_busy, tx_done, rx_done, rx_data, rx_read,
    input  baud_tick, tx_start, loadTXactive, loadTXdone, loadRXdone,
           rx_buf, rx_valid, rx_overrun, tx_timeout, irq
  );
endinterface

// File: rtl/uart_ctrl.sv
// UART sequencer: baud tick generation, TX launch/ack FSM with status strobes, one-entry RX buffer.
// state | meaning: IDLE wait start req | START pulse tx_start | WAIT_ACK await busy/done | ACTIVE await done | DONE strobe done | HOLD wait req clear
module uart_ctrl #(
  parameter int BASE_DIV    = 27,
  parameter int DIV_W       = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst_n,
  uart_ctrl_if.slave bus
);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q;
  logic             tick_q, tick_d;

  logic [2:0]       state_q, state_d;
  logic [ACK_W-1:0] ack_q, ack_d;
  logic             to_q, to_d;
  logic             to_this_q, to_this_d;
  logic             tx_start_q, txact_q, txdone_q;

  logic [7:0]       buf_q, buf_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             rxload_q, rx_hit;
  logic             irq_q, irq_d;
  logic             conf_unused;

  assign conf_unused = ^bus.conf[7:5];
  assign div = DIV_W'(BASE_DIV) << bus.conf[2:0];

  // A baud-select change restarts the period and swallows that cycle's tick.
  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (bus.conf[2:0] != sel_q) begin
      cnt_d = '0;
    end else if (cnt_q == div - DIV_W'(1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    to_d      = to_q;
    to_this_d = to_this_q;
    case (state_q)
      S_IDLE:   if (bus.conf[4] && !bus.tx_busy) state_d = S_START;
      S_START: begin
        ack_d     = ACK_W'(ACK_TIMEOUT - 1);
        to_this_d = 1'b0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          state_d = S_DONE;
        end else if (bus.tx_busy) begin
          state_d = S_ACTIVE;
        end else if (ack_q == '0) begin
          to_d      = 1'b1;
          to_this_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          ack_d = ack_q - ACK_W'(1);
        end
      end
      S_ACTIVE: if (bus.tx_done) state_d = S_DONE;
      S_DONE: begin
        // A timeout from an earlier TX is only cleared by a later successful one.
        if (!to_this_q) to_d = 1'b0;
        state_d = S_HOLD;
      end
      S_HOLD:   if (!bus.conf[4]) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign rx_hit = bus.rx_done & bus.conf[3];

  always_comb begin
    buf_d   = buf_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (rx_hit) begin
      if (!valid_q || bus.rx_read) begin
        buf_d   = bus.rx_data;
        valid_d = 1'b1;
        if (bus.rx_read) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (bus.rx_read) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    irq_d = valid_d | ovr_d | (state_d == S_DONE) | (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sel_q      <= '0;
      tick_q     <= 1'b0;
      state_q    <= S_IDLE;
      ack_q      <= '0;
      to_q       <= 1'b0;
      to_this_q  <= 1'b0;
      tx_start_q <= 1'b0;
      txact_q    <= 1'b0;
      txdone_q   <= 1'b0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      rxload_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sel_q      <= bus.conf[2:0];
      tick_q     <= tick_d;
      state_q    <= state_d;
      ack_q      <= ack_d;
      to_q       <= to_d;
      to_this_q  <= to_this_d;
      tx_start_q <= (state_d == S_START);
      txact_q    <= (state_q == S_WAIT) && (state_d == S_ACTIVE);
      txdone_q   <= (state_d == S_DONE);
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      rxload_q   <= rx_hit;
      irq_q      <= irq_d;
    end
  end

  assign bus.baud_tick    = tick_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.loadTXactive = txact_q;
  assign bus.loadTXdone   = txdone_q;
  assign bus.loadRXdone   = rxload_q;
  assign bus.rx_buf       = buf_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_overrun   = ovr_q;
  assign bus.tx_timeout   = to_q;
  assign bus.irq          = irq_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed plus randomized bench for uart_ctrl with a behavioural baud/RX reference model.
module tb_uart_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_ctrl_if u_if ();

  uart_ctrl #(.BASE_DIV(27), .DIV_W(16), .ACK_TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int errs = 0;
  int checks = 0;

  // baud model: cycles since the period last restarted
  int         b_since = 0;
  logic [2:0] b_sel = 3'd0;
  logic       b_exp = 1'b0;

  // RX buffer model
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic [7:0] m_buf = 8'h00;
  logic       m_load = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {15'd0, u_if.baud_tick, u_if.tx_start, u_if.loadTXactive, u_if.loadTXdone,
            u_if.loadRXdone, u_if.rx_buf, u_if.rx_valid, u_if.rx_overrun,
            u_if.tx_timeout, u_if.irq};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      b_since = 0; b_sel = 3'd0; b_exp = 1'b0;
    end else if (u_if.conf[2:0] != b_sel) begin
      b_since = 0; b_sel = u_if.conf[2:0]; b_exp = 1'b0;
    end else begin
      b_since++;
      b_exp = ((b_since % (27 << b_sel)) == 0);
    end
    #1;
    chk("baud_tick", u_if.baud_tick, b_exp);
    chk("strobe_excl", ($countones({u_if.tx_start, u_if.loadTXactive, u_if.loadTXdone}) <= 1), 1);
  endtask

  task automatic rx_cycle(input logic done, input logic [7:0] data, input logic rd);
    u_if.rx_done = done;
    u_if.rx_data = data;
    u_if.rx_read = rd;
    m_load = done & u_if.conf[3];
    if (m_load) begin
      if (!m_valid || rd) begin
        m_buf = data; m_valid = 1'b1;
        if (rd) m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (rd) begin
      m_valid = 1'b0; m_ovr = 1'b0;
    end
    tick();
    u_if.rx_done = 1'b0;
    u_if.rx_read = 1'b0;
    chk("loadRXdone", u_if.loadRXdone, m_load);
    chk("rx_buf", u_if.rx_buf, m_buf);
    chk("rx_valid", u_if.rx_valid, m_valid);
    chk("rx_overrun", u_if.rx_overrun, m_ovr);
    chk("rx_irq", u_if.irq, m_valid | m_ovr);
  endtask

  task automatic do_tx(input int busy_dly, input int done_dly, input logic prev_to);
    u_if.conf = 8'h10;
    tick();
    chk("tx_start", u_if.tx_start, 1);
    repeat (busy_dly) begin
      tick();
      chk("tx_start_once", u_if.tx_start, 0);
      chk("no_txactive", u_if.loadTXactive, 0);
    end
    u_if.tx_busy = 1'b1;
    tick();
    chk("loadTXactive", u_if.loadTXactive, 1);
    tick();
    chk("loadTXactive_end", u_if.loadTXactive, 0);
    repeat (done_dly) begin
      tick();
      chk("no_txdone", u_if.loadTXdone, 0);
    end
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    u_if.tx_busy = 1'b0;
    chk("loadTXdone", u_if.loadTXdone, 1);
    chk("irq_done", u_if.irq, 1);
    chk("timeout_in_done", u_if.tx_timeout, prev_to);
    tick();
    chk("loadTXdone_end", u_if.loadTXdone, 0);
    chk("irq_hold", u_if.irq, 1);
    chk("timeout_cleared", u_if.tx_timeout, 0);
    repeat (4) begin
      tick();
      chk("hold_no_restart", u_if.tx_start, 0);
    end
    u_if.conf = 8'h00;
    tick();
    chk("irq_idle", u_if.irq, 0);
    repeat (4) begin
      tick();
      chk("idle_no_start", u_if.tx_start, 0);
    end
  endtask

  initial begin
    u_if.conf = 8'h00;
    u_if.tx_busy = 1'b0;
    u_if.tx_done = 1'b0;
    u_if.rx_done = 1'b0;
    u_if.rx_data = 8'h00;
    u_if.rx_read = 1'b0;

    repeat (3) begin
      tick();
      chk("reset_outs", all_outs(), 0);
    end
    rst_n = 1'b1;

    // baud: 27-cycle period, then select 3 gives 216
    repeat (60) tick();
    u_if.conf = 8'h03;
    repeat (450) tick();
    u_if.conf = 8'h00;
    repeat (5) tick();

    // RX single byte and read
    u_if.conf = 8'h08;
    rx_cycle(1'b1, 8'hA5, 1'b0);
    chk("rx_single_buf", u_if.rx_buf, 8'hA5);
    rx_cycle(1'b0, 8'h00, 1'b0);
    rx_cycle(1'b0, 8'h00, 1'b1);
    chk("rx_read_irq", u_if.irq, 0);

    // overrun then simultaneous done+read
    rx_cycle(1'b1, 8'h11, 1'b0);
    rx_cycle(1'b1, 8'h22, 1'b0);
    chk("ovr_buf", u_if.rx_buf, 8'h11);
    chk("ovr_flag", u_if.rx_overrun, 1);
    rx_cycle(1'b1, 8'h33, 1'b1);
    chk("simul_buf", u_if.rx_buf, 8'h33);
    chk("simul_ovr", u_if.rx_overrun, 0);
    rx_cycle(1'b0, 8'h00, 1'b1);

    // RX disabled
    u_if.conf = 8'h00;
    rx_cycle(1'b1, 8'h77, 1'b0);
    chk("rx_disabled_valid", u_if.rx_valid, 0);

    // randomized RX traffic
    repeat (300) begin
      u_if.conf = ($urandom_range(0, 4) != 0) ? 8'h08 : 8'h00;
      rx_cycle(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0);
    end
    rx_cycle(1'b0, 8'h00, 1'b1);
    u_if.conf = 8'h00;

    // normal TX, then randomized handshake delays
    do_tx(2, 100, 1'b0);
    repeat (3) do_tx($urandom_range(1, 6), $urandom_range(0, 40), 1'b0);

    // tx_done with tx_busy in WAIT_ACK: done wins
    u_if.conf = 8'h10;
    tick();
    tick();
    u_if.tx_busy = 1'b1;
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_busy = 1'b0;
    u_if.tx_done = 1'b0;
    chk("prio_no_txactive", u_if.loadTXactive, 0);
    chk("prio_txdone", u_if.loadTXdone, 1);
    u_if.conf = 8'h00;
    repeat (2) tick();
    chk("prio_idle_irq", u_if.irq, 0);

    // TX timeout
    u_if.conf = 8'h10;
    tick();
    chk("to_tx_start", u_if.tx_start, 1);
    tick();
    for (int i = 0; i < 254; i++) begin
      tick();
      chk("to_not_yet", {u_if.tx_timeout, u_if.loadTXdone}, 2'b00);
    end
    tick();
    chk("to_flag", u_if.tx_timeout, 1);
    chk("to_txdone", u_if.loadTXdone, 1);
    chk("to_irq", u_if.irq, 1);
    repeat (3) begin
      tick();
      chk("to_hold_irq", u_if.irq, 1);
      chk("to_hold_txdone", u_if.loadTXdone, 0);
    end
    u_if.conf = 8'h00;
    tick();
    chk("to_irq_clear", u_if.irq, 0);
    chk("to_sticky", u_if.tx_timeout, 1);
    do_tx(3, 10, 1'b1);

    // reset while ACTIVE
    u_if.conf = 8'h10;
    tick();
    tick();
    u_if.tx_busy = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    u_if.conf = 8'h00;
    u_if.tx_busy = 1'b0;
    #1;
    chk("midtx_reset_outs", all_outs(), 0);
    repeat (2) begin
      tick();
      chk("midtx_reset_hold", all_outs(), 0);
    end
    rst_n = 1'b1;
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    repeat (20) begin
      tick();
      chk("post_reset_no_txdone", u_if.loadTXdone, 0);
      chk("post_reset_no_start", u_if.tx_start, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Sequencer and scheduler for the UART datapath and its configuration/status register.
- Generates the oversampling baud tick from the config baud-select bits, launches TX when software sets the start bit, and pulses the status-register load strobes (loadTXactive, loadTXdone, loadRXdone) at the right cycles.
- Holds the received byte in a one-entry buffer with overrun detection and an interrupt output.
- Sits between the config register, the TX/RX shift engines and the MCU bus.

Parameters:
- BASE_DIV, 27, baud divisor for conf[2:0]=0 (clk/(16*baud)); effective divisor = BASE_DIV << conf[2:0].
- DIV_W, 16, baud counter width; must hold (BASE_DIV<<7)-1.
- ACK_TIMEOUT, 255, cycles to wait for tx_busy after tx_start before forcing completion.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (rst==0 resets)
- conf  in  8  config/status register contents; [2:0] baud select, [3] rx enable, [4] tx start request
- tx_busy  in  1  TX engine active (TXactive)
- tx_done  in  1  TX engine one-cycle completion pulse
- rx_done  in  1  RX engine one-cycle byte-received pulse
- rx_data  in  8  RX engine byte, valid with rx_done
- rx_read  in  1  bus read of rx_buf, one-cycle pulse
- baud_tick  out  1  one-cycle pulse every divisor clocks
- tx_start  out  1  one-cycle pulse to the TX engine
- loadTXactive  out  1  status strobe
- loadTXdone  out  1  status strobe
- loadRXdone  out  1  status strobe
- rx_buf  out  8  held received byte
- rx_valid  out  1  rx_buf holds unread data
- rx_overrun  out  1  byte lost because rx_buf was full
- tx_timeout  out  1  sticky; last TX never acknowledged
- irq  out  1  interrupt request, level

Behaviour:
- All outputs are registered. On rst low: every output is 0, baud counter is 0, FSM is in IDLE. Reset is honoured in any state; an in-flight TX is abandoned and no strobe is emitted.
- Baud generator:
  - Counter counts 0..div-1, with div = BASE_DIV << conf[2:0].
  - baud_tick=1 in the cycle after the counter reaches div-1; the counter then reloads 0.
  - Any change of conf[2:0] (compared with a registered copy) clears the counter and suppresses the tick for that cycle.
- TX FSM, states IDLE, START, WAIT_ACK, ACTIVE, DONE, HOLD:
  - IDLE: conf[4]==1 and tx_busy==0 -> START.
  - START: tx_start=1 for exactly one cycle; clear the ack counter -> WAIT_ACK.
  - WAIT_ACK:
    - tx_busy==1 -> loadTXactive=1 for one cycle -> ACTIVE.
    - tx_done==1 (same or earlier cycle as tx_busy) -> DONE; this takes priority over the ack transition.
    - Ack counter reaches ACK_TIMEOUT -> tx_timeout=1 -> DONE.
  - ACTIVE: tx_done==1 -> DONE.
  - DONE: loadTXdone=1 for one cycle; clear tx_timeout unless it was set by this TX -> HOLD.
  - HOLD: wait until conf[4]==0, which the register clears on loadTXdone -> IDLE. This guarantees one TX per start request.
  - tx_start, loadTXactive and loadTXdone are never high in the same cycle.
- RX path (only when conf[3]==1; otherwise rx_done is ignored and the buffer is untouched):
  - rx_done with rx_valid==0: rx_buf<=rx_data, rx_valid<=1.
  - rx_done with rx_valid==1 and no rx_read: data discarded, rx_overrun<=1.
  - rx_done and rx_read in the same cycle: new byte accepted, rx_valid stays 1, no overrun.
  - rx_read alone: rx_valid<=0, rx_overrun<=0.
  - loadRXdone=1 one cycle after every accepted or discarded rx_done.
- irq = rx_valid | rx_overrun | (FSM in DONE or HOLD).

Test Plan:
- Reset/baud: release rst, conf=0x00, BASE_DIV=27 -> first baud_tick at cycle 27 after release, then every 27 cycles; set conf[2:0]=3 -> counter restarts, ticks every 216 cycles.
- Normal TX: conf[4]=1, tx_busy rises 2 cycles after tx_start, tx_done 100 cycles later -> exactly one tx_start, loadTXactive in the cycle after tx_busy is seen, loadTXdone one cycle after tx_done, FSM back to IDLE once conf[4]=0, no second tx_start.
- TX timeout: conf[4]=1, tx_busy held 0 -> tx_timeout=1 after 255 cycles in WAIT_ACK, loadTXdone pulses, irq high until conf[4] cleared.
- RX single: conf[3]=1, rx_done with rx_data=0xA5 -> rx_buf=0xA5, rx_valid=1, loadRXdone next cycle, irq=1; rx_read -> rx_valid=0, irq=0.
- RX overrun/simultaneous: two rx_done pulses (0x11, 0x22) without a read -> rx_buf=0x11, rx_overrun=1; then rx_done 0x33 with rx_read in the same cycle -> rx_buf=0x33, rx_valid=1, rx_overrun=0. With conf[3]=0, rx_done has no effect.
- Reset mid-TX: assert rst low while in ACTIVE -> all outputs 0 immediately, no loadTXdone after release until a new start request.
